// File: rtl/vx_scalar_dispatch_unit.sv
// -----------------------------------------------------------------------------
// vx_scalar_dispatch_unit
// Execute-side receiver of the dispatch handshake. Round-robin arbitrates
// ISSUE_CNT dispatch channels into one execution block and splits each
// THREAD_CNT-wide instruction into LANE_CNT-wide packets, one per cycle,
// tagged with sop/eop/pid.
//
// Optional feature macro: VX_DISPATCH_SKIP_EMPTY_EN
//   defined     : packets whose lane mask is zero are not emitted (an all-zero
//                 instruction still emits pid 0 as a single sop/eop packet).
//   not defined : every packet 0..PKT_CNT-1 is emitted in order.
//
// Dispatch word layout, MSB->LSB: {hdr, tmask, rs1, rs2, rs3}, thread 0 at LSB.
// -----------------------------------------------------------------------------
module vx_scalar_dispatch_unit #(
   parameter int ISSUE_CNT  = 4,
   parameter int THREAD_CNT = 4,
   parameter int LANE_CNT   = 2,
   parameter int XLEN       = 32,
   parameter int HDR_W      = 64,
   localparam int PKT_CNT   = THREAD_CNT / LANE_CNT,
   localparam int PID_W     = (PKT_CNT > 1) ? $clog2(PKT_CNT) : 1,
   localparam int ISSUE_W   = (ISSUE_CNT > 1) ? $clog2(ISSUE_CNT) : 1,
   localparam int DATAW     = HDR_W + THREAD_CNT + 3 * THREAD_CNT * XLEN
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [ISSUE_CNT-1:0]                 disp_valid,
   input  logic [ISSUE_CNT-1:0][DATAW-1:0]      disp_data,
   output logic [ISSUE_CNT-1:0]                 disp_ready,
   output logic                                 exe_valid,
   input  logic                                 exe_ready,
   output logic [HDR_W-1:0]                     exe_hdr,
   output logic [ISSUE_W-1:0]                   exe_issue_idx,
   output logic [LANE_CNT-1:0]                  exe_tmask,
   output logic [LANE_CNT*XLEN-1:0]             exe_rs1,
   output logic [LANE_CNT*XLEN-1:0]             exe_rs2,
   output logic [LANE_CNT*XLEN-1:0]             exe_rs3,
   output logic [PID_W-1:0]                     exe_pid,
   output logic                                 exe_sop,
   output logic                                 exe_eop
);

   // Field offsets inside one dispatch word.
   localparam int OPS_W  = THREAD_CNT * XLEN;
   localparam int RS3_LO = 0;
   localparam int RS2_LO = OPS_W;
   localparam int RS1_LO = 2 * OPS_W;
   localparam int TM_LO  = 3 * OPS_W;
   localparam int HDR_LO = TM_LO + THREAD_CNT;
   localparam int SLC_W  = LANE_CNT * XLEN;

   // Arbitration / sequencing state.
   logic [ISSUE_W-1:0]    rr_ptr;
   logic [ISSUE_W-1:0]    lock_idx;
   logic                  lock;
   logic [PID_W-1:0]      cur_pid;

   // Combinational decisions for the current cycle.
   logic [ISSUE_W-1:0]    grant;
   logic                  grant_valid;
   logic                  load;
   logic                  fire;
   logic                  is_last;
   logic [PID_W-1:0]      emit_pid;
   logic [PID_W-1:0]      next_pid;

   // Fields of the granted channel's word.
   logic [DATAW-1:0]      grant_word;
   logic [HDR_W-1:0]      grant_hdr;
   logic [THREAD_CNT-1:0] grant_tmask;
   logic [OPS_W-1:0]      grant_rs1;
   logic [OPS_W-1:0]      grant_rs2;
   logic [OPS_W-1:0]      grant_rs3;

   assign grant_word  = disp_data[grant];
   assign grant_hdr   = grant_word[HDR_LO +: HDR_W];
   assign grant_tmask = grant_word[TM_LO  +: THREAD_CNT];
   assign grant_rs1   = grant_word[RS1_LO +: OPS_W];
   assign grant_rs2   = grant_word[RS2_LO +: OPS_W];
   assign grant_rs3   = grant_word[RS3_LO +: OPS_W];

   // The output register can take a new packet when empty or being drained.
   assign load = !exe_valid || exe_ready;
   assign fire = load && grant_valid && !reset;

   // Arbiter: hold the locked channel, otherwise first valid at/after rr_ptr.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
      grant       = lock_idx;
      grant_valid = 1'b0;
      if (lock) begin
         grant_valid = disp_valid[lock_idx];
      end else begin
         // Scan from farthest to nearest so the nearest valid channel wins.
         for (int i = ISSUE_CNT - 1; i >= 0; i--) begin
            if (disp_valid[ISSUE_W'((int'(rr_ptr) + i) % ISSUE_CNT)]) begin
               grant       = ISSUE_W'((int'(rr_ptr) + i) % ISSUE_CNT);
               grant_valid = 1'b1;
            end
         end
      end
   end

`ifdef VX_DISPATCH_SKIP_EMPTY_EN
   logic [PKT_CNT-1:0] slice_nz;
   logic [PID_W-1:0]   first_pid;

   // Packet selection skipping lane slices whose mask is all zero.
   always_comb begin
      for (int p = 0; p < PKT_CNT; p++) begin
         slice_nz[p] = |grant_tmask[p*LANE_CNT +: LANE_CNT];
      end
      // An all-zero instruction still emits pid 0.
      first_pid = '0;
      for (int p = PKT_CNT - 1; p >= 0; p--) begin
         if (slice_nz[p]) first_pid = PID_W'(p);
      end
      emit_pid = lock ? cur_pid : first_pid;
      next_pid = emit_pid;
      is_last  = 1'b1;
      for (int p = PKT_CNT - 1; p >= 0; p--) begin
         if (slice_nz[p] && (PID_W'(p) > emit_pid)) begin
            next_pid = PID_W'(p);
            is_last  = 1'b0;
         end
      end
   end
`else
   // Packet selection walking every pid in order, empty slices included.
   always_comb begin
      emit_pid = lock ? cur_pid : '0;
      is_last  = (emit_pid == PID_W'(PKT_CNT - 1));
      next_pid = emit_pid + PID_W'(1);
   end
`endif

   // Handshake back to the granted channel only when its last packet loads.
   always_comb begin
      disp_ready = '0;
      if (fire && is_last) disp_ready[grant] = 1'b1;
   end

   // Lock / pid / round-robin pointer sequencing.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         lock     <= 1'b0;
         lock_idx <= '0;
         cur_pid  <= '0;
         rr_ptr   <= '0;
      end else if (fire) begin
         if (is_last) begin
            lock    <= 1'b0;
            cur_pid <= '0;
            rr_ptr  <= ISSUE_W'((int'(grant) + 1) % ISSUE_CNT);
         end else begin
            lock     <= 1'b1;
            lock_idx <= grant;
            cur_pid  <= next_pid;
         end
      end
   end

   // Registered output stage; holds while the execution block stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         exe_valid     <= 1'b0;
         exe_hdr       <= '0;
         exe_issue_idx <= '0;
         exe_tmask     <= '0;
         exe_rs1       <= '0;
         exe_rs2       <= '0;
         exe_rs3       <= '0;
         exe_pid       <= '0;
         exe_sop       <= 1'b0;
         exe_eop       <= 1'b0;
      end else if (load) begin
         exe_valid <= grant_valid;
         if (grant_valid) begin
            exe_hdr       <= grant_hdr;
            exe_issue_idx <= grant;
            exe_tmask     <= grant_tmask[emit_pid*LANE_CNT +: LANE_CNT];
            exe_rs1       <= grant_rs1[emit_pid*SLC_W +: SLC_W];
            exe_rs2       <= grant_rs2[emit_pid*SLC_W +: SLC_W];
            exe_rs3       <= grant_rs3[emit_pid*SLC_W +: SLC_W];
            exe_pid       <= emit_pid;
            exe_sop       <= !lock;
            exe_eop       <= is_last;
         end
      end
   end

endmodule

// File: tb/tb_vx_scalar_dispatch_unit.sv
// -----------------------------------------------------------------------------
// tb_vx_scalar_dispatch_unit
// Directed scenarios plus randomized traffic, every cycle compared against a
// packet-list reference model of the dispatch unit.
// -----------------------------------------------------------------------------
module tb_vx_scalar_dispatch_unit;

   localparam int N       = 4;
   localparam int T       = 4;
   localparam int L       = 2;
   localparam int X       = 32;
   localparam int HDR_W   = 64;
   localparam int PKT_CNT = T / L;
   localparam int PID_W   = 1;
   localparam int ISSUE_W = 2;
   localparam int DATAW   = HDR_W + T + 3 * T * X;
   localparam int OPS_W   = T * X;
   localparam int TM_LO   = 3 * OPS_W;
   localparam int HDR_LO  = TM_LO + T;

   typedef struct packed {
      logic [HDR_W-1:0]   hdr;
      logic [ISSUE_W-1:0] idx;
      logic [L-1:0]       tmask;
      logic [L*X-1:0]     rs1;
      logic [L*X-1:0]     rs2;
      logic [L*X-1:0]     rs3;
      logic [PID_W-1:0]   pid;
      logic               sop;
      logic               eop;
   } pkt_t;

   logic                       clk = 1'b0;
   logic                       reset;
   logic [N-1:0]               disp_valid;
   logic [N-1:0][DATAW-1:0]    disp_data;
   logic [N-1:0]               disp_ready;
   logic                       exe_valid;
   logic                       exe_ready;
   logic [HDR_W-1:0]           exe_hdr;
   logic [ISSUE_W-1:0]         exe_issue_idx;
   logic [L-1:0]               exe_tmask;
   logic [L*X-1:0]             exe_rs1, exe_rs2, exe_rs3;
   logic [PID_W-1:0]           exe_pid;
   logic                       exe_sop, exe_eop;

   int checks = 0;
   int errors = 0;

   // Bench-side channel state and reference model state.
   bit               ch_valid [N];
   logic [DATAW-1:0] ch_word  [N];
   pkt_t             pkt_q[$];
   pkt_t             t_q[$];
   pkt_t             m_pkt;
   bit               m_valid;
   int               m_rr;
   bit               p_load, p_take;
   logic [N-1:0]     p_ready;
   logic [N-1:0]     last_ready;

   vx_scalar_dispatch_unit dut (
      .clk(clk), .reset(reset),
      .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
      .exe_valid(exe_valid), .exe_ready(exe_ready),
      .exe_hdr(exe_hdr), .exe_issue_idx(exe_issue_idx), .exe_tmask(exe_tmask),
      .exe_rs1(exe_rs1), .exe_rs2(exe_rs2), .exe_rs3(exe_rs3),
      .exe_pid(exe_pid), .exe_sop(exe_sop), .exe_eop(exe_eop)
   );

   always #5 clk = ~clk;

   function automatic logic [DATAW-1:0] rand_word(input logic [T-1:0] tm);
      logic [DATAW-1:0] w;
      for (int k = 0; k < DATAW; k++) w[k] = 1'($urandom_range(0, 1));
      w[TM_LO +: T] = tm;
      return w;
   endfunction

   // Expand one instruction into the list of packets it must produce.
   function automatic void expand(input int c, input logic [DATAW-1:0] w);
      logic [T-1:0]     tm;
      logic [OPS_W-1:0] r1, r2, r3;
      int               pids[$];
      pkt_t             pk;
      tm = w[TM_LO +: T];
      r1 = w[2*OPS_W +: OPS_W];
      r2 = w[OPS_W +: OPS_W];
      r3 = w[0 +: OPS_W];
      for (int p = 0; p < PKT_CNT; p++) begin
`ifdef VX_DISPATCH_SKIP_EMPTY_EN
         if (tm[p*L +: L] == '0) continue;
`endif
         pids.push_back(p);
      end
      if (pids.size() == 0) pids.push_back(0);
      t_q.delete();
      for (int k = 0; k < pids.size(); k++) begin
         pk.hdr   = w[HDR_LO +: HDR_W];
         pk.idx   = ISSUE_W'(c);
         pk.tmask = tm[pids[k]*L +: L];
         pk.rs1   = r1[pids[k]*L*X +: L*X];
         pk.rs2   = r2[pids[k]*L*X +: L*X];
         pk.rs3   = r3[pids[k]*L*X +: L*X];
         pk.pid   = PID_W'(pids[k]);
         pk.sop   = (k == 0);
         pk.eop   = (k == pids.size() - 1);
         t_q.push_back(pk);
      end
   endfunction

   // Predict what the coming clock edge does, given the driven inputs.
   task automatic predict();
      p_ready = '0;
      p_take  = 1'b0;
      p_load  = !m_valid || exe_ready;
      t_q     = pkt_q;
      if (!reset && p_load) begin
         if (t_q.size() == 0) begin
            for (int i = 0; i < N; i++) begin
               if (ch_valid[(m_rr + i) % N]) begin
                  expand((m_rr + i) % N, ch_word[(m_rr + i) % N]);
                  break;
               end
            end
         end
         if (t_q.size() != 0) begin
            p_take = 1'b1;
            if (t_q.size() == 1) p_ready[t_q[0].idx] = 1'b1;
         end
      end
   endtask

   // One clock cycle: drive, check handshake, advance model, check outputs.
   task automatic step();
      pkt_t got;
      for (int c = 0; c < N; c++) begin
         disp_valid[c] = ch_valid[c];
         disp_data[c]  = ch_word[c];
      end
      #1;
      predict();
      checks++;
      if (disp_ready !== p_ready) begin
         errors++;
         $display("FAIL disp_ready: got %b expected %b at %0t", disp_ready, p_ready, $time);
      end
      last_ready = disp_ready;
      @(posedge clk);
      if (reset) begin
         m_valid = 1'b0;
         m_pkt   = '0;
         m_rr    = 0;
         pkt_q.delete();
      end else if (p_load) begin
         m_valid = p_take;
         if (p_take) begin
            m_pkt = t_q.pop_front();
            pkt_q = t_q;
         end
         for (int c = 0; c < N; c++) begin
            if (p_ready[c]) begin
               ch_valid[c] = 1'b0;
               m_rr = (c + 1) % N;
            end
         end
      end
      @(negedge clk);
      checks++;
      if (exe_valid !== m_valid) begin
         errors++;
         $display("FAIL exe_valid: got %b expected %b at %0t", exe_valid, m_valid, $time);
      end
      if (m_valid) begin
         got = {exe_hdr, exe_issue_idx, exe_tmask, exe_rs1, exe_rs2, exe_rs3,
                exe_pid, exe_sop, exe_eop};
         checks++;
         if (got !== m_pkt) begin
            errors++;
            $display("FAIL packet: got %h expected %h at %0t", got, m_pkt, $time);
         end
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      exe_ready = 1'b1;
      for (int c = 0; c < N; c++) ch_valid[c] = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      exe_ready   = 1'b1;
      ch_valid[0] = 1'b1;
      ch_word[0]  = rand_word(4'hF);
      step();
      step();
      checks++;
      if ({exe_valid, exe_hdr, exe_issue_idx, exe_tmask, exe_rs1, exe_rs2, exe_rs3,
           exe_pid, exe_sop, exe_eop} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got nonzero outputs, expected all zero");
      end
      checks++;
      if (last_ready !== '0) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 0000", last_ready);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      ch_valid[0] = 1'b1;
      ch_word[0]  = rand_word(4'b1111);
      ch_word[0][2*OPS_W +: OPS_W] = {32'd4, 32'd3, 32'd2, 32'd1};
      step();
      checks++;
      if (!(exe_valid === 1'b1 && exe_pid === 1'b0 && exe_sop === 1'b1 && exe_eop === 1'b0 &&
            exe_tmask === 2'b11 && exe_rs1 === {32'd2, 32'd1} && last_ready === 4'b0000)) begin
         errors++;
         $display("FAIL single_pid0: got pid %0d sop %b eop %b tmask %b rs1 %h ready %b, expected pid 0 sop 1 eop 0 tmask 11 rs1 0000000200000001 ready 0000",
                  exe_pid, exe_sop, exe_eop, exe_tmask, exe_rs1, last_ready);
      end
      step();
      checks++;
      if (!(exe_valid === 1'b1 && exe_pid === 1'b1 && exe_sop === 1'b0 && exe_eop === 1'b1 &&
            exe_rs1 === {32'd4, 32'd3} && last_ready === 4'b0001)) begin
         errors++;
         $display("FAIL single_pid1: got pid %0d sop %b eop %b rs1 %h ready %b, expected pid 1 sop 0 eop 1 rs1 0000000400000003 ready 0001",
                  exe_pid, exe_sop, exe_eop, exe_rs1, last_ready);
      end
      step();
   endtask

   task automatic test_back_to_back();
      do_reset();
      exe_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < N; c++) begin
            if (!ch_valid[c]) begin
               ch_valid[c] = 1'b1;
               ch_word[c]  = rand_word(4'hF);
            end
         end
         step();
         checks++;
         if (!(exe_valid === 1'b1 && exe_issue_idx === ISSUE_W'((i / 2) % N) &&
               exe_pid === PID_W'(i % 2))) begin
            errors++;
            $display("FAIL rr_order[%0d]: got valid %b idx %0d pid %0d, expected valid 1 idx %0d pid %0d",
                     i, exe_valid, exe_issue_idx, exe_pid, (i / 2) % N, i % 2);
         end
      end
      do_reset();
   endtask

   task automatic test_stall();
      logic [L*X-1:0] held_rs1;
      int             hs = 0;
      do_reset();
      ch_valid[2] = 1'b1;
      ch_word[2]  = rand_word(4'hF);
      exe_ready   = 1'b1;
      step();
      held_rs1 = exe_rs1;
      exe_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (!(exe_valid === 1'b1 && exe_pid === 1'b0 && exe_rs1 === held_rs1 && last_ready === '0)) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got valid %b pid %0d ready %b, expected valid 1 pid 0 ready 0000 with held data",
                     i, exe_valid, exe_pid, last_ready);
         end
      end
      exe_ready = 1'b1;
      step();
      if (last_ready[2]) hs++;
      checks++;
      if (!(exe_pid === 1'b1 && exe_eop === 1'b1 && last_ready === 4'b0100)) begin
         errors++;
         $display("FAIL stall_release: got pid %0d eop %b ready %b, expected pid 1 eop 1 ready 0100",
                  exe_pid, exe_eop, last_ready);
      end
      exe_ready = 1'b0;
      step();
      if (last_ready[2]) hs++;
      step();
      if (last_ready[2]) hs++;
      exe_ready = 1'b1;
      step();
      if (last_ready[2]) hs++;
      checks++;
      if (hs != 1 || exe_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_handshakes: got %0d handshakes valid %b, expected 1 handshake valid 0", hs, exe_valid);
      end
   endtask

   task automatic test_partial_mask();
      do_reset();
      ch_valid[0] = 1'b1;
      ch_word[0]  = rand_word(4'b1100);
      step();
`ifdef VX_DISPATCH_SKIP_EMPTY_EN
      checks++;
      if (!(exe_pid === 1'b1 && exe_sop === 1'b1 && exe_eop === 1'b1 && exe_tmask === 2'b11)) begin
         errors++;
         $display("FAIL partial_skip: got pid %0d sop %b eop %b tmask %b, expected pid 1 sop 1 eop 1 tmask 11",
                  exe_pid, exe_sop, exe_eop, exe_tmask);
      end
      step();
`else
      checks++;
      if (!(exe_pid === 1'b0 && exe_sop === 1'b1 && exe_tmask === 2'b00)) begin
         errors++;
         $display("FAIL partial_pid0: got pid %0d sop %b tmask %b, expected pid 0 sop 1 tmask 00",
                  exe_pid, exe_sop, exe_tmask);
      end
      step();
      checks++;
      if (!(exe_pid === 1'b1 && exe_eop === 1'b1 && exe_tmask === 2'b11)) begin
         errors++;
         $display("FAIL partial_pid1: got pid %0d eop %b tmask %b, expected pid 1 eop 1 tmask 11",
                  exe_pid, exe_eop, exe_tmask);
      end
`endif
      // An all-zero mask is still dispatched.
      ch_valid[1] = 1'b1;
      ch_word[1]  = rand_word(4'b0000);
      step();
      checks++;
      if (!(exe_valid === 1'b1 && exe_issue_idx === 2'd1 && exe_sop === 1'b1 && exe_pid === 1'b0)) begin
         errors++;
         $display("FAIL zero_mask: got valid %b idx %0d sop %b pid %0d, expected valid 1 idx 1 sop 1 pid 0",
                  exe_valid, exe_issue_idx, exe_sop, exe_pid);
      end
      step();
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      ch_valid[2] = 1'b1;
      ch_word[2]  = rand_word(4'hF);
      step();
      step();
      ch_valid[1] = 1'b1;
      ch_word[1]  = rand_word(4'hF);
      step();
      checks++;
      if (!(exe_issue_idx === 2'd1 && exe_pid === 1'b0)) begin
         errors++;
         $display("FAIL mid_pre: got idx %0d pid %0d, expected idx 1 pid 0", exe_issue_idx, exe_pid);
      end
      reset       = 1'b1;
      ch_valid[3] = 1'b1;
      ch_word[3]  = rand_word(4'hF);
      step();
      checks++;
      if (!(exe_valid === 1'b0 && last_ready === '0)) begin
         errors++;
         $display("FAIL mid_reset: got valid %b ready %b, expected valid 0 ready 0000", exe_valid, last_ready);
      end
      reset = 1'b0;
      step();
      checks++;
      if (!(exe_valid === 1'b1 && exe_issue_idx === 2'd1 && exe_pid === 1'b0 && exe_sop === 1'b1)) begin
         errors++;
         $display("FAIL mid_restart: got valid %b idx %0d pid %0d sop %b, expected valid 1 idx 1 pid 0 sop 1",
                  exe_valid, exe_issue_idx, exe_pid, exe_sop);
      end
      for (int i = 0; i < 6; i++) step();
   endtask

   task automatic test_random();
      logic [T-1:0] tm;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         exe_ready = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < N; c++) begin
            if (!ch_valid[c] && $urandom_range(0, 2) == 0) begin
               tm          = ($urandom_range(0, 7) == 0) ? '0 : T'($urandom);
               ch_valid[c] = 1'b1;
               ch_word[c]  = rand_word(tm);
            end
         end
         step();
      end
   endtask

   initial begin
      reset      = 1'b1;
      exe_ready  = 1'b1;
      disp_valid = '0;
      disp_data  = '0;
      m_valid    = 1'b0;
      m_pkt      = '0;
      m_rr       = 0;
      for (int c = 0; c < N; c++) begin
         ch_valid[c] = 1'b0;
         ch_word[c]  = '0;
      end
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_partial_mask();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
